// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the unpack/pack datapaths.
package fp_pkg;

  localparam int unsigned      FP_BIAS    = 127;
  localparam int unsigned      FP_EXP_MAX = 255;
  localparam logic signed [9:0] FP_E_SUB  = -10'sd126;
  localparam logic signed [9:0] FP_E_INF  = 10'sd128;

  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} fp_class_t;

  typedef struct packed {
    logic       s;
    logic [9:0] e;
    logic [23:0] m;
  } fp_unpacked_t;

  function automatic fp_class_t fp_classify(input logic [7:0] exp_f, input logic [22:0] frac_f);
    if (exp_f == '0) return (frac_f == '0) ? ZERO : SUB;
    if (exp_f == 8'(FP_EXP_MAX)) return (frac_f == '0) ? INF : NAN;
    return NORM;
  endfunction

endpackage

// File: rtl/fp_unpack_bits_if.sv
// Valid/ready input word and unpacked result bundle of fp_unpack_bits.
interface fp_unpack_bits_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] n;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] n_m;
  logic [9:0]  n_e;
  logic        n_s;
  logic        is_zero;
  logic        is_sub;
  logic        is_inf;
  logic        is_nan;

  modport master (
    output in_valid, n, out_ready,
    input  in_ready, out_valid, n_m, n_e, n_s, is_zero, is_sub, is_inf, is_nan
  );

  modport slave (
    input  in_valid, n, out_ready,
    output in_ready, out_valid, n_m, n_e, n_s, is_zero, is_sub, is_inf, is_nan
  );

endinterface

// File: rtl/fp_lzc24.sv
// Leading-zero count of a 24-bit vector; all-zero input yields 24.
module fp_lzc24 (
  input  logic [23:0] vec_i,
  output logic [4:0]  cnt_o
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    cnt_o = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (vec_i[i]) cnt_o = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp_unpack_bits.sv
// Two-stage single-precision unpacker: S1 splits and classifies, S2 normalizes and registers.
module fp_unpack_bits
  import fp_pkg::*;
#(
  parameter bit NORMALIZE = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  fp_unpack_bits_if.slave bus
);

  logic         s1_valid_q;
  logic         s1_s_q;
  logic [7:0]   s1_exp_q;
  logic [22:0]  s1_frac_q;
  fp_class_t    s1_class_q;

  logic         s2_valid_q;
  fp_unpacked_t s2_q, s2_d;
  logic [3:0]   s2_flags_q, s2_flags_d;  // {zero, sub, inf, nan}

  logic         s1_advance;
  logic         in_fire;
  logic [23:0]  frac_ext;
  logic [4:0]   lz;

  assign s1_advance   = !s2_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid_q || s1_advance;
  assign in_fire      = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_exp_q   <= '0;
      s1_frac_q  <= '0;
      s1_class_q <= ZERO;
    end else begin
      if (bus.in_ready) s1_valid_q <= bus.in_valid;
      if (in_fire) begin
        s1_s_q     <= bus.n[31];
        s1_exp_q   <= bus.n[30:23];
        s1_frac_q  <= bus.n[22:0];
        s1_class_q <= fp_classify(bus.n[30:23], bus.n[22:0]);
      end
    end
  end

  assign frac_ext = {1'b0, s1_frac_q};

  fp_lzc24 u_lzc (
    .vec_i (frac_ext),
    .cnt_o (lz)
  );

  always_comb begin
    s2_d.s     = s1_s_q;
    s2_d.m     = frac_ext;
    s2_d.e     = FP_E_SUB;
    s2_flags_d = 4'b0000;
    unique case (s1_class_q)
      NORM: begin
        s2_d.m = {1'b1, s1_frac_q};
        s2_d.e = {2'b00, s1_exp_q} - 10'(FP_BIAS);
      end
      ZERO: begin
        s2_d.m     = '0;
        s2_flags_d = 4'b1000;
      end
      SUB: begin
        s2_flags_d = 4'b0100;
        if (NORMALIZE) begin
          s2_d.m = frac_ext << lz;
          s2_d.e = FP_E_SUB - 10'(lz);
        end
      end
      INF: begin
        s2_d.m     = '0;
        s2_d.e     = FP_E_INF;
        s2_flags_d = 4'b0010;
      end
      NAN: begin
        s2_d.e     = FP_E_INF;
        s2_flags_d = 4'b0001;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_flags_q <= '0;
    end else if (s1_advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_q       <= s2_d;
        s2_flags_q <= s2_flags_d;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.n_m       = s2_q.m;
  assign bus.n_e       = s2_q.e;
  assign bus.n_s       = s2_q.s;
  assign bus.is_zero   = s2_flags_q[3];
  assign bus.is_sub    = s2_flags_q[2];
  assign bus.is_inf    = s2_flags_q[1];
  assign bus.is_nan    = s2_flags_q[0];

endmodule

// File: tb/tb_fp_unpack_bits.sv
// Scoreboard bench driving a normalizing and a raw-subnormal unpacker with the same stream.
module tb_fp_unpack_bits;

  localparam int NV = 14;
  typedef logic [38:0] res_t;  // {s, e[9:0], m[23:0], zero, sub, inf, nan}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] n_in = '0;

  int total = 0;
  int bad = 0;
  int n_out_n = 0;
  int n_out_r = 0;

  logic [31:0] vn [NV];
  res_t        vr1 [NV];
  res_t        vr0 [NV];
  res_t        q_n [$];
  res_t        q_r [$];
  res_t        obs_n, obs_r;

  always #5 clk = ~clk;

  fp_unpack_bits_if bus_n ();
  fp_unpack_bits_if bus_r ();

  assign bus_n.in_valid  = in_valid;
  assign bus_n.n         = n_in;
  assign bus_n.out_ready = out_ready;
  assign bus_r.in_valid  = in_valid;
  assign bus_r.n         = n_in;
  assign bus_r.out_ready = out_ready;

  fp_unpack_bits #(.NORMALIZE(1'b1)) u_norm (.clk(clk), .rst_n(rst_n), .bus(bus_n));
  fp_unpack_bits #(.NORMALIZE(1'b0)) u_raw  (.clk(clk), .rst_n(rst_n), .bus(bus_r));

  assign obs_n = {bus_n.n_s, bus_n.n_e, bus_n.n_m,
                  bus_n.is_zero, bus_n.is_sub, bus_n.is_inf, bus_n.is_nan};
  assign obs_r = {bus_r.n_s, bus_r.n_e, bus_r.n_m,
                  bus_r.is_zero, bus_r.is_sub, bus_r.is_inf, bus_r.is_nan};

  function automatic res_t mk(input logic s, input int e, input logic [23:0] m,
                              input logic [3:0] f);
    return {s, 10'(e), m, f};
  endfunction

  task automatic set_vec(input int i, input logic [31:0] n, input logic s, input int e1,
                         input logic [23:0] m1, input int e0, input logic [23:0] m0,
                         input logic [3:0] f);
    vn[i]  = n;
    vr1[i] = mk(s, e1, m1, f);
    vr0[i] = mk(s, e0, m0, f);
  endtask

  task automatic chk(input string name, input res_t got, input res_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got s=%0b e=%0d m=%h f=%b, want s=%0b e=%0d m=%h f=%b", name,
               got[38], $signed(got[37:28]), got[27:4], got[3:0],
               want[38], $signed(want[37:28]), want[27:4], want[3:0]);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Offer vector idx from a falling edge until the rising edge that accepts it.
  task automatic send(input int idx, output int waited);
    logic done;
    done   = 1'b0;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    n_in     = vn[idx];
    while (!done) begin
      #1;
      if (bus_n.in_ready) begin
        @(posedge clk);
        q_n.push_back(vr1[idx]);
        q_r.push_back(vr0[idx]);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 50) begin
          total++;
          bad++;
          $display("FAIL accept_timeout: got in_ready=0 for 50 cycles want 1");
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic idle(input int cycles);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (cycles - 1) @(negedge clk);
  endtask

  // Monitor: pops on each transfer, and checks outputs are frozen while stalled.
  initial begin : monitor
    res_t held_n, held_r;
    logic hv_n, hv_r;
    hv_n = 1'b0;
    hv_r = 1'b0;
    held_n = '0;
    held_r = '0;
    forever begin
      @(negedge clk);
      #2;
      if (hv_n && bus_n.out_valid) chk("hold_norm", obs_n, held_n);
      if (hv_r && bus_r.out_valid) chk("hold_raw", obs_r, held_r);
      hv_n   = bus_n.out_valid && !bus_n.out_ready;
      hv_r   = bus_r.out_valid && !bus_r.out_ready;
      held_n = obs_n;
      held_r = obs_r;
      if (bus_n.out_valid && bus_n.out_ready) begin
        n_out_n++;
        if (q_n.size() == 0) chk_int("unexpected_norm_out", 1, 0);
        else chk("result_norm", obs_n, q_n.pop_front());
      end
      if (bus_r.out_valid && bus_r.out_ready) begin
        n_out_r++;
        if (q_r.size() == 0) chk_int("unexpected_raw_out", 1, 0);
        else chk("result_raw", obs_r, q_r.pop_front());
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int w, wmax, cnt_n, cnt_r;
    logic saw_bp;

    set_vec(0,  32'h44923456, 1'b0,   10, 24'h923456,   10, 24'h923456, 4'b0000);
    set_vec(1,  32'hC9F89ABC, 1'b1,   20, 24'hF89ABC,   20, 24'hF89ABC, 4'b0000);
    set_vec(2,  32'h00000001, 1'b0, -149, 24'h800000, -126, 24'h000001, 4'b0100);
    set_vec(3,  32'h00000000, 1'b0, -126, 24'h000000, -126, 24'h000000, 4'b1000);
    set_vec(4,  32'h7F800000, 1'b0,  128, 24'h000000,  128, 24'h000000, 4'b0010);
    set_vec(5,  32'hFF800000, 1'b1,  128, 24'h000000,  128, 24'h000000, 4'b0010);
    set_vec(6,  32'h7FC00000, 1'b0,  128, 24'h400000,  128, 24'h400000, 4'b0001);
    set_vec(7,  32'h80000000, 1'b1, -126, 24'h000000, -126, 24'h000000, 4'b1000);
    set_vec(8,  32'h00400000, 1'b0, -127, 24'h800000, -126, 24'h400000, 4'b0100);
    set_vec(9,  32'h3F800000, 1'b0,    0, 24'h800000,    0, 24'h800000, 4'b0000);
    set_vec(10, 32'h7F7FFFFF, 1'b0,  127, 24'hFFFFFF,  127, 24'hFFFFFF, 4'b0000);
    set_vec(11, 32'h00800000, 1'b0, -126, 24'h800000, -126, 24'h800000, 4'b0000);
    set_vec(12, 32'h807FFFFF, 1'b1, -127, 24'hFFFFFE, -126, 24'h7FFFFF, 4'b0100);
    set_vec(13, 32'hFFFFFFFF, 1'b1,  128, 24'h7FFFFF,  128, 24'h7FFFFF, 4'b0001);

    // Reset state.
    #12;
    chk_int("rst_out_valid", int'(bus_n.out_valid), 0);
    chk_int("rst_in_ready", int'(bus_n.in_ready), 1);
    chk("rst_outputs_norm", obs_n, '0);
    chk("rst_outputs_raw", obs_r, '0);

    // Release just after a rising edge; the next rising edge must accept.
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(0, w);
    chk_int("first_edge_accept", w, 0);

    // Latency: accepting cycle is cycle 1, result is presented in cycle 2.
    @(negedge clk);
    in_valid = 1'b0;
    #2 chk_int("latency_not_early", int'(bus_n.out_valid), 0);
    @(negedge clk);
    #2 chk_int("latency_present", int'(bus_n.out_valid), 1);
    idle(2);

    // Back-to-back stream with out_ready high: no bubbles anywhere.
    wmax = 0;
    for (int i = 0; i < NV; i++) begin
      send(i, w);
      if (w > wmax) wmax = w;
    end
    chk_int("stream_in_ready_held", wmax, 0);
    idle(1);
    @(negedge clk);
    #3;
    chk_int("stream_drained_norm", q_n.size(), 0);
    chk_int("stream_drained_raw", q_r.size(), 0);
    idle(2);

    // Backpressure: out_ready low in stream cycles 3..6.
    saw_bp = 1'b0;
    cnt_n  = n_out_n;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(i, w);
          if (w > 0) saw_bp = 1'b1;
        end
      end
      begin
        for (int c = 1; c <= 7; c++) begin
          @(negedge clk);
          out_ready = !(c >= 3 && c <= 6);
        end
      end
    join
    chk_int("bp_in_ready_dropped", int'(saw_bp), 1);
    idle(10);
    chk_int("bp_count_norm", n_out_n - cnt_n, 8);
    chk_int("bp_drained_norm", q_n.size(), 0);
    chk_int("bp_drained_raw", q_r.size(), 0);

    // Reset with both stages full.
    @(negedge clk);
    out_ready = 1'b0;
    send(1, w);
    send(6, w);
    @(negedge clk);
    in_valid = 1'b0;
    #2 chk_int("full_before_reset", int'(bus_n.out_valid), 1);
    #1 rst_n = 1'b0;
    q_n.delete();
    q_r.delete();
    #1;
    chk_int("async_rst_out_valid_norm", int'(bus_n.out_valid), 0);
    chk_int("async_rst_out_valid_raw", int'(bus_r.out_valid), 0);
    chk_int("async_rst_in_ready", int'(bus_n.in_ready), 1);
    chk("async_rst_outputs", obs_n, '0);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    cnt_n = n_out_n;
    cnt_r = n_out_r;
    #1 rst_n = 1'b1;
    send(9, w);
    chk_int("first_edge_accept_after_rst", w, 0);
    idle(6);
    chk_int("no_stale_norm", n_out_n - cnt_n, 1);
    chk_int("no_stale_raw", n_out_r - cnt_r, 1);
    chk_int("post_rst_drained", q_n.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
